// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master data-memory arbiter with round-robin, locked bursts and starvation hand-over.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mN_req/we/addr/wdata/lock      requester N access (m0 = CPU MEM stage, m1 = loader/DMA)
//   mN_gnt                         access performed this cycle (combinational)
//   mN_rdata/mN_rvalid             registered read data and its one-cycle valid pulse
//   cpu_stall                      m0 requesting but not granted
//   align_err                      pulse one cycle after a granted misaligned access
//   mem_read/write/addr/wdata      data memory drive, mem_rdata combinational read data
module dmem_arbiter #(
    parameter int MAX_LOCK = 16,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic [31:0]       m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic [31:0]       m1_rdata,
    output logic              m1_rvalid,
    output logic              cpu_stall,
    output logic              align_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_LOCK);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     lock_cnt, cnt_n;
    logic              last_gnt;
    logic              own0, own1, cap, idle_g0, idle_g1, any_gnt, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    always_comb begin
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        state_n = state;
        cnt_n   = lock_cnt;
        own0    = (state == LOCK0) & m0_req & m0_lock;
        own1    = (state == LOCK1) & m1_req & m1_lock;
        cap     = lock_cnt == MAX_C;
        // last_gnt = 1 means m1 was served last, so m0 wins the tie
        idle_g0 = m0_req & (~m1_req | last_gnt);
        idle_g1 = m1_req & ~idle_g0;
        if (own0) begin
            if (cap & m1_req) begin
                m1_gnt  = 1'b1;
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                m0_gnt = 1'b1;
                cnt_n  = cap ? MAX_C : lock_cnt + CW'(1);
            end
        end else if (own1) begin
            if (cap & m0_req) begin
                m0_gnt  = 1'b1;
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                m1_gnt = 1'b1;
                cnt_n  = cap ? MAX_C : lock_cnt + CW'(1);
            end
        end else begin
            // owner released (or no owner): arbitrate as IDLE, possibly entering a new lock
            m0_gnt  = idle_g0;
            m1_gnt  = idle_g1;
            state_n = (idle_g0 & m0_lock) ? LOCK0 : (idle_g1 & m1_lock) ? LOCK1 : IDLE;
            cnt_n   = (state_n == IDLE) ? '0 : CW'(1);
        end
        if (rst) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end
    end

    assign any_gnt   = m0_gnt | m1_gnt;
    assign sel_we    = m1_gnt ? m1_we : m0_we;
    assign sel_addr  = m1_gnt ? m1_addr : m0_addr;
    assign sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign mem_read  = any_gnt & ~sel_we;
    // misaligned writes are suppressed; misaligned reads still fetch the word
    assign mem_write = any_gnt & sel_we & (sel_addr[1:0] == 2'b00);
    assign mem_addr  = any_gnt ? sel_addr : '0;
    assign mem_wdata = any_gnt ? sel_wdata : '0;
    assign cpu_stall = m0_req & ~m0_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lock_cnt  <= '0;
            last_gnt  <= 1'b1;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            align_err <= 1'b0;
        end else begin
            state     <= state_n;
            lock_cnt  <= cnt_n;
            last_gnt  <= any_gnt ? m1_gnt : last_gnt;
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
            align_err <= any_gnt & (sel_addr[1:0] != 2'b00);
            if (m0_gnt & ~m0_we) m0_rdata <= mem_rdata;
            if (m1_gnt & ~m1_we) m1_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, cpu_stall, align_err, mem_read, mem_write;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        ld = 1'b0;
    logic [7:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] mem [256];
    int          vec = 0;
    int          errs = 0;

    dmem_arbiter #(.MAX_LOCK(16), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .cpu_stall(cpu_stall), .align_err(align_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld) mem[ld_idx] <= ld_data;
        else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] d);
        ld = 1; ld_idx = idx; ld_data = d;
        tick();
        ld = 0;
    endtask

    task automatic test_reset();
        clr();
        m0_req = 1; m1_req = 1; m1_lock = 1; m1_we = 1;
        rst = 1;
        #2;
        vec++; if (m0_gnt !== 1'b0) begin errs++; $display("FAIL rst_m0_gnt got %b want 0", m0_gnt); end
        vec++; if (m1_gnt !== 1'b0) begin errs++; $display("FAIL rst_m1_gnt got %b want 0", m1_gnt); end
        vec++; if (mem_read !== 1'b0) begin errs++; $display("FAIL rst_mem_read got %b want 0", mem_read); end
        vec++; if (mem_write !== 1'b0) begin errs++; $display("FAIL rst_mem_write got %b want 0", mem_write); end
        tick();
        vec++; if (m0_rvalid !== 1'b0) begin errs++; $display("FAIL rst_m0_rvalid got %b want 0", m0_rvalid); end
        vec++; if (m1_rvalid !== 1'b0) begin errs++; $display("FAIL rst_m1_rvalid got %b want 0", m1_rvalid); end
        vec++; if (align_err !== 1'b0) begin errs++; $display("FAIL rst_align_err got %b want 0", align_err); end
        vec++; if (m0_rdata !== 32'h0) begin errs++; $display("FAIL rst_m0_rdata got %h want 0", m0_rdata); end
        vec++; if (m1_rdata !== 32'h0) begin errs++; $display("FAIL rst_m1_rdata got %h want 0", m1_rdata); end
        rst = 0;
        clr();
    endtask

    task automatic test_single_read();
        do_reset();
        load(8'd4, 32'hDEADBEEF);
        m0_req = 1; m0_addr = 32'h10;
        #2;
        vec++; if (m0_gnt !== 1'b1) begin errs++; $display("FAIL rd_m0_gnt got %b want 1", m0_gnt); end
        vec++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL rd_stall got %b want 0", cpu_stall); end
        vec++; if (mem_read !== 1'b1) begin errs++; $display("FAIL rd_mem_read got %b want 1", mem_read); end
        vec++; if (mem_addr !== 32'h10) begin errs++; $display("FAIL rd_mem_addr got %h want 10", mem_addr); end
        tick();
        clr();
        vec++; if (m0_rvalid !== 1'b1) begin errs++; $display("FAIL rd_rvalid got %b want 1", m0_rvalid); end
        vec++; if (m0_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_rdata got %h want deadbeef", m0_rdata); end
        tick();
        vec++; if (m0_rvalid !== 1'b0) begin errs++; $display("FAIL rd_rvalid_drop got %b want 0", m0_rvalid); end
        vec++; if (m0_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_rdata_hold got %h want deadbeef", m0_rdata); end
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_req = 1; m0_addr = 32'h0;
        m1_req = 1; m1_addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            logic e0;
            e0 = (i % 2) == 0;
            #2;
            vec++; if (m0_gnt !== e0) begin errs++; $display("FAIL rr_m0_gnt[%0d] got %b want %b", i, m0_gnt, e0); end
            vec++; if (m1_gnt !== !e0) begin errs++; $display("FAIL rr_m1_gnt[%0d] got %b want %b", i, m1_gnt, !e0); end
            vec++; if (cpu_stall !== !e0) begin errs++; $display("FAIL rr_stall[%0d] got %b want %b", i, cpu_stall, !e0); end
            tick();
        end
        clr();
    endtask

    task automatic test_lock_burst();
        int k;
        do_reset();
        k = 0;
        m1_req = 1; m1_lock = 1; m1_we = 1;
        for (int c = 1; c <= 18; c++) begin
            logic e1;
            m1_addr  = 32'h80 + 32'(4 * k);
            m1_wdata = 32'(k);
            m0_req   = c >= 2;
            e1 = (c <= 16) || (c == 18);
            #2;
            vec++; if (m1_gnt !== e1) begin errs++; $display("FAIL lk_m1_gnt[%0d] got %b want %b", c, m1_gnt, e1); end
            vec++; if (m0_gnt !== (!e1 && c >= 2)) begin errs++; $display("FAIL lk_m0_gnt[%0d] got %b want %b", c, m0_gnt, !e1 && c >= 2); end
            tick();
            if (e1) k++;
        end
        clr();
        tick();
        vec++; if (mem[47] !== 32'd15) begin errs++; $display("FAIL lk_mem47 got %h want f", mem[47]); end
        vec++; if (mem[48] !== 32'd16) begin errs++; $display("FAIL lk_mem48 got %h want 10", mem[48]); end
    endtask

    task automatic test_misaligned();
        do_reset();
        load(8'd8, 32'h11111111);
        m0_req = 1; m0_we = 1; m0_addr = 32'h22; m0_wdata = 32'h4;
        #2;
        vec++; if (m0_gnt !== 1'b1) begin errs++; $display("FAIL ma_m0_gnt got %b want 1", m0_gnt); end
        vec++; if (mem_write !== 1'b0) begin errs++; $display("FAIL ma_mem_write got %b want 0", mem_write); end
        tick();
        clr();
        vec++; if (align_err !== 1'b1) begin errs++; $display("FAIL ma_wr_align got %b want 1", align_err); end
        m0_req = 1; m0_addr = 32'h22;
        #2;
        vec++; if (mem_read !== 1'b1) begin errs++; $display("FAIL ma_mem_read got %b want 1", mem_read); end
        tick();
        clr();
        vec++; if (align_err !== 1'b1) begin errs++; $display("FAIL ma_rd_align got %b want 1", align_err); end
        vec++; if (m0_rdata !== 32'h11111111) begin errs++; $display("FAIL ma_rdata got %h want 11111111", m0_rdata); end
        vec++; if (mem[8] !== 32'h11111111) begin errs++; $display("FAIL ma_mem got %h want 11111111", mem[8]); end
        tick();
        vec++; if (align_err !== 1'b0) begin errs++; $display("FAIL ma_align_drop got %b want 0", align_err); end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        m1_req = 1; m1_lock = 1; m1_we = 1; m1_addr = 32'h100; m1_wdata = 32'h55;
        tick(); tick(); tick();
        m0_req = 1; m0_addr = 32'h0;
        rst = 1;
        #2;
        vec++; if (m1_gnt !== 1'b0) begin errs++; $display("FAIL rl_m1_gnt got %b want 0", m1_gnt); end
        vec++; if (m0_gnt !== 1'b0) begin errs++; $display("FAIL rl_m0_gnt got %b want 0", m0_gnt); end
        vec++; if (mem_write !== 1'b0) begin errs++; $display("FAIL rl_mem_write got %b want 0", mem_write); end
        tick();
        rst = 0;
        #2;
        vec++; if (m0_gnt !== 1'b1) begin errs++; $display("FAIL rl_post_m0 got %b want 1", m0_gnt); end
        vec++; if (m1_gnt !== 1'b0) begin errs++; $display("FAIL rl_post_m1 got %b want 0", m1_gnt); end
        tick();
        clr();
    endtask

    task automatic test_back_to_back();
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'hCAFE0001;
        #2;
        vec++; if (m1_gnt !== 1'b1) begin errs++; $display("FAIL bb_m1_gnt got %b want 1", m1_gnt); end
        vec++; if (mem_write !== 1'b1) begin errs++; $display("FAIL bb_mem_write got %b want 1", mem_write); end
        tick();
        clr();
        m0_req = 1; m0_addr = 32'h40;
        #2;
        vec++; if (m0_gnt !== 1'b1) begin errs++; $display("FAIL bb_m0_gnt got %b want 1", m0_gnt); end
        tick();
        clr();
        vec++; if (m0_rvalid !== 1'b1) begin errs++; $display("FAIL bb_rvalid got %b want 1", m0_rvalid); end
        vec++; if (m0_rdata !== 32'hCAFE0001) begin errs++; $display("FAIL bb_rdata got %h want cafe0001", m0_rdata); end
    endtask

    initial begin
        clr();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_misaligned();
        test_reset_mid_lock();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MAX_LOCK, default 16, SHALL set the maximum consecutive locked grants before forced hand-over.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width of requester and memory ports.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Ports mN_req  input  1  SHALL be the access request from requester N, N in {0,1}; m0 is the CPU MEM stage, m1 is the loader/DMA.
REQ-006 Ports mN_we  input  1  SHALL select write (1) or read (0).
REQ-007 Ports mN_addr  input  ADDR_W  SHALL be the byte address.
REQ-008 Ports mN_wdata  input  32  SHALL be the write data.
REQ-009 Ports mN_lock  input  1  SHALL request ownership hold across consecutive cycles (burst).
REQ-010 Ports mN_gnt  output  1  SHALL indicate the access is performed this cycle (combinational).
REQ-011 Ports mN_rdata  output  32  SHALL be the registered read data.
REQ-012 Ports mN_rvalid  output  1  SHALL pulse one cycle after a granted read.
REQ-013 Port cpu_stall  output  1  SHALL equal m0_req & ~m0_gnt.
REQ-014 Port align_err  output  1  SHALL pulse one cycle after a granted access with addr[1:0] != 0.
REQ-015 Ports mem_read, mem_write  output  1  SHALL drive the data memory read/write enables.
REQ-016 Ports mem_addr  output  ADDR_W, mem_wdata  output  32  SHALL drive the data memory address and data.
REQ-017 Port mem_rdata  input  32  SHALL be the data memory combinational read data.

Function
REQ-018 At most one mN_gnt SHALL be high per cycle; a grant is given only to an asserted mN_req.
REQ-019 FSM states IDLE, LOCK0, LOCK1; reset state IDLE.
REQ-020 In IDLE with one requester: grant it; with both: grant requester != last_gnt (round-robin); last_gnt resets to 1 (m0 wins first tie).
REQ-021 IDLE -> LOCKn when requester n is granted with mN_lock=1; lock_cnt loads 1.
REQ-022 In LOCKn: requester n granted while mN_req & mN_lock; other requester not granted; lock_cnt increments per grant.
REQ-023 LOCKn -> IDLE when mN_req=0 or mN_lock=0 (grant in that cycle decided by IDLE rules).
REQ-024 LOCKn with lock_cnt == MAX_LOCK and the other requester asserting: the other SHALL be granted that cycle, FSM -> IDLE; with no competing request, lock_cnt saturates at MAX_LOCK and ownership continues.
REQ-025 mem_addr/mem_wdata/mem_read/mem_write SHALL mux from the granted requester; mem_read = gnt & ~we; mem_write = gnt & we & aligned; all zero with no grant.
REQ-026 Misaligned granted write SHALL NOT assert mem_write; misaligned read performs access of addr word; both raise align_err next cycle.
REQ-027 Granted read SHALL capture mem_rdata into mN_rdata at that posedge; mN_rvalid high the following cycle only; mN_rdata holds until next read for N.
REQ-028 last_gnt SHALL update to the granted index every grant cycle.
REQ-029 Write-then-read same address in consecutive grants SHALL return new data (dmem write lands at the first posedge).

Reset
REQ-030 With rst=1 at posedge: FSM=IDLE, last_gnt=1, lock_cnt=0, mN_rdata=0, mN_rvalid=0, align_err=0.
REQ-031 During rst=1, mN_gnt, mem_read and mem_write SHALL be 0; a locked burst interrupted by reset is abandoned.

Verification
REQ-032 m0 read 0x10 alone, mem holds 0xDEADBEEF -> m0_gnt same cycle, m0_rvalid next cycle, m0_rdata=0xDEADBEEF, cpu_stall=0.
REQ-033 Both request continuously, no lock -> grants alternate m0,m1,m0,m1; cpu_stall high on m1 cycles.
REQ-034 m1 lock burst of 20 writes with m0 requesting, MAX_LOCK=16 -> m1 granted 16 cycles, m0 granted cycle 17, then round-robin.
REQ-035 m0 write 0x4 addr 0x22 -> mem_write=0, align_err pulse next cycle, memory unchanged.
REQ-036 rst asserted mid LOCK1 burst -> gnt=0 that cycle; after release both requesting -> m0 granted first.
REQ-037 m1 writes 0xCAFE0001 to 0x40, m0 reads 0x40 next cycle -> m0_rdata=0xCAFE0001.
